// File: rtl/cdb_rr_arbiter_if.sv
// rtl/cdb_rr_arbiter_if.sv - request/broadcast bundle between reservation stations, CDB arbiter and ROB
interface cdb_rr_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      cdb_stall;
  logic                      flush;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;

  modport master (
    output req_valid, req_tag, req_data, cdb_stall, flush,
    input  grant, cdb_valid, cdb_tag, cdb_data
  );

  modport slave (
    input  req_valid, req_tag, req_data, cdb_stall, flush,
    output grant, cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/cdb_rr_arbiter.sv
// rtl/cdb_rr_arbiter.sv - round-robin Common Data Bus arbiter with registered broadcast
// Optional starvation monitor (starve_flag port) enabled by defining CDB_STARVE_MON_EN.
module cdb_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 16
) (
  input  logic clk,
  input  logic rst,
  cdb_rr_arbiter_if.slave bus
`ifdef CDB_STARVE_MON_EN
  ,
  output logic starve_flag
`endif
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]   NUM_EXT  = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;

  logic               grant_en;
  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_vec;
  logic [PTR_W:0]     scan_sum;
  logic [PTR_W-1:0]   scan_idx;

  // Scan from rr_ptr upward with an explicit modulo so non-power-of-2 sizes never leave range.
  always_comb begin
    grant_en  = !rst && !bus.flush && !bus.cdb_stall;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_sum >= NUM_EXT) begin
        scan_sum = scan_sum - NUM_EXT;
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (grant_en && !grant_any && bus.req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (grant_any) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = grant_any;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    if (grant_any) begin
      rr_ptr_d   = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      cdb_tag_d  = bus.req_tag[grant_idx*TAG_W +: TAG_W];
      cdb_data_d = bus.req_data[grant_idx*DATA_W +: DATA_W];
    end
    if (bus.flush) begin
      rr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  assign bus.grant     = grant_vec;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;

`ifdef CDB_STARVE_MON_EN
  logic [3:0] wait_cnt_q [NUM_REQ];
  logic [3:0] wait_cnt_d [NUM_REQ];
  logic       starve_q, starve_d;

  // Flag follows the next-state counters so it rises and clears one cycle after the event.
  always_comb begin
    starve_d = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_cnt_d[i] = wait_cnt_q[i];
      if (bus.flush || !bus.req_valid[i] || grant_vec[i]) begin
        wait_cnt_d[i] = 4'd0;
      end else if (wait_cnt_q[i] != 4'hF) begin
        wait_cnt_d[i] = wait_cnt_q[i] + 4'd1;
      end
      if (wait_cnt_d[i] == 4'hF) begin
        starve_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        wait_cnt_q[i] <= 4'd0;
      end
    end else begin
      starve_q <= starve_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        wait_cnt_q[i] <= wait_cnt_d[i];
      end
    end
  end

  assign starve_flag = starve_q;
`endif
endmodule

// File: doc/cdb_rr_arbiter.md
Name: cdb_rr_arbiter

Overview:
- Round-robin scheduler that shares the single Common Data Bus between NUM_REQ functional-unit reservation stations in the Tomasulo datapath.
- Each station holds a finished result (tag + data) and requests the bus. The block grants one requester per cycle and drives a registered CDB broadcast to the ROB and the reservation stations.
- Supports a ROB back-pressure stall and a mispredict flush.

Parameters:
- NUM_REQ, 3, number of requesting reservation stations (2..8).
- TAG_W, 3, ROB tag width carried on the CDB.
- DATA_W, 16, result data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  bit i = station i holds a result.
- req_tag  input  NUM_REQ*TAG_W  packed tags, station i at [i*TAG_W +: TAG_W].
- req_data  input  NUM_REQ*DATA_W  packed data, station i at [i*DATA_W +: DATA_W].
- grant  output  NUM_REQ  one-hot, combinational; station i may release its entry at the next edge.
- cdb_stall  input  1  ROB cannot accept a broadcast this cycle.
- flush  input  1  mispredict; kill all in-flight broadcast.
- cdb_valid  output  1  registered broadcast valid.
- cdb_tag  output  TAG_W  registered broadcast tag.
- cdb_data  output  DATA_W  registered broadcast data.

Behaviour:
- Reset (rst=1 at an edge): cdb_valid=0, cdb_tag=0, cdb_data=0, rr_ptr=0. grant is 0 while rst is high.
- rr_ptr selects the highest-priority index. The search order is rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ.
- Grant condition: rst=0, flush=0, cdb_stall=0 and req_valid nonzero. Under that condition grant sets exactly one bit, the first valid index in search order. Otherwise grant=0.
- Handshake: a requester holds valid/tag/data stable until it sees its grant bit. It may deassert or present a new result on the cycle after the grant.
- Latency: granted tag/data appear on cdb_tag/cdb_data with cdb_valid=1 one cycle after the grant cycle.
- If no grant occurs in a cycle, cdb_valid=0 the next cycle. cdb_tag/cdb_data hold their last value, and consumers ignore them while cdb_valid=0.
- Pointer update: on a grant to index g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Wrap-around: g = NUM_REQ-1 sets rr_ptr to 0. A non-power-of-2 NUM_REQ never yields an out-of-range pointer.
- cdb_stall=1: no grant, and cdb_valid=0 next cycle. The requests stay pending and lose no priority.
- flush=1: no grant, cdb_valid=0 next cycle and rr_ptr <= 0. Flush takes priority over stall.
- rst mid-operation: any pending broadcast is dropped, and the outputs take their reset values at that edge.
- Single requester: that requester is granted every cycle while it stays valid and there is no stall or flush. Back-to-back broadcasts give a throughput of 1 per cycle.
- Fairness: any continuously valid requester is granted within NUM_REQ grant cycles.

Optional Feature:
- Macro: CDB_STARVE_MON_EN.
- With the macro defined:
  - Adds output starve_flag (1 bit, registered) and per-requester 4-bit saturating wait counters.
  - Counter i increments when req_valid[i]=1 and grant[i]=0. It clears when grant[i]=1 or req_valid[i]=0, and clears on rst or flush.
  - starve_flag=1 the cycle after any counter reaches 15. It is 0 on reset.
- Without the macro: no counters and no starve_flag port. Arbitration behaviour is identical in both cases.

Test Plan:
- Reset, then req_valid=3'b111 with tags 1,2,3 and data 16'h0011/0022/0033 held continuously. Required: grants 001, 010, 100, 001 on consecutive cycles; cdb_tag sequence 1,2,3,1, one cycle later each.
- Only station 2 valid with tag 5, data 16'hBEEF. Required: grant=100 in the same cycle, and next cycle cdb_valid=1, cdb_tag=5, cdb_data=16'hBEEF. The following grant is again 100 (the pointer wraps to 0).
- req_valid=3'b011 with cdb_stall=1 for 3 cycles. Required: grant=0 and cdb_valid=0 throughout. After release, station 0 is granted first (rr_ptr unchanged).
- Grant to station 1, then flush=1 in the next cycle with req_valid=3'b110. Required: the broadcast from station 1 appears (it was registered before the flush). In the flush cycle grant=0, and the next cycle cdb_valid=0. After the flush, station 1 is granted first because rr_ptr=0 and station 0 is not valid.
- Assert rst for one cycle while cdb_valid=1. Required: cdb_valid=0 and cdb_tag=0 the next cycle, and the first grant after reset goes to the lowest valid index.
- CDB_STARVE_MON_EN defined, NUM_REQ=3. Station 0 valid continuously while cdb_stall=1 for 16 cycles. Required: starve_flag=1 from the cycle after the counter reaches 15. It clears the cycle after station 0 is granted.
